// File: rtl/simpson_poly_integrator.sv
// Button-loaded Simpson's-rule integrator for a degree-DEG signed polynomial.
// Horner evaluation at a, (a+b)/2 and b, then a sequential restoring divide by 6.
module simpson_poly_integrator #(
    parameter int W   = 16,
    parameter int DEG = 3,
    parameter int RW  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          btn,
    input  logic [W-1:0]  sw,
    output logic [RW-1:0] result,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [3:0]    load_idx
);
    localparam int NS   = DEG + 3;
    localparam int CNTW = $clog2(RW + 1) + 1;

    typedef enum logic [2:0] {S_LOAD, S_EVAL, S_SUM, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [3:0]        load_idx_q, load_idx_d;
    logic [RW-1:0]     slot_q [NS];
    logic [RW-1:0]     slot_d [NS];
    logic [RW-1:0]     f_q [3];
    logic [RW-1:0]     f_d [3];
    logic [RW-1:0]     acc_q, acc_d, dvd_q, dvd_d, quo_q, quo_d, result_q, result_d;
    logic [1:0]        pt_q, pt_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        rem_q, rem_d;
    logic              p_neg_q, p_neg_d, ovf_q, ovf_d;

    function automatic logic signed [2*RW-1:0] sx2(input logic [RW-1:0] v);
        return {{RW{v[RW-1]}}, v};
    endfunction

    function automatic logic fits2(input logic signed [2*RW-1:0] v);
        return v == sx2(v[RW-1:0]);
    endfunction

    logic                   press;
    logic [RW-1:0]          sw_ext, a_val, b_val, m_val, x_val, coef;
    logic signed [2*RW-1:0] mid_full, prod, t4, s1, s2, diff, pf;
    logic [RW:0]            hsum;
    logic [RW-1:0]          pw;
    logic                   sum_ovf, step_ovf, q_bit;
    logic [3:0]             rem_sh;

    always_comb begin
        press    = sync2_q & ~prev_q;
        sw_ext   = {{(RW-W){sw[W-1]}}, sw};
        a_val    = slot_q[DEG+1];
        b_val    = slot_q[DEG+2];
        mid_full = sx2(a_val) + sx2(b_val);
        m_val    = mid_full[RW:1];
        x_val    = a_val;
        if (pt_q == 2'd1) x_val = m_val;
        if (pt_q == 2'd2) x_val = b_val;
        coef = '0;
        for (int i = 0; i < NS; i++)
            if (cnt_q == CNTW'(i)) coef = slot_q[i];
        // Horner step: full-width product for the range check, RW-bit wrap for the datapath
        prod     = sx2(acc_q) * sx2(x_val);
        hsum     = {prod[RW-1], prod[RW-1:0]} + {coef[RW-1], coef};
        step_ovf = !fits2(prod) || (hsum[RW] != hsum[RW-1]);
        t4       = sx2(f_q[1]) <<< 2;
        s1       = sx2(f_q[0]) + sx2(t4[RW-1:0]);
        s2       = sx2(s1[RW-1:0]) + sx2(f_q[2]);
        diff     = sx2(b_val) - sx2(a_val);
        pf       = sx2(diff[RW-1:0]) * sx2(s2[RW-1:0]);
        pw       = pf[RW-1:0];
        sum_ovf  = !fits2(t4) || !fits2(s1) || !fits2(s2) || !fits2(diff) || !fits2(pf);
        rem_sh   = {rem_q, dvd_q[RW-1]};
        q_bit    = rem_sh >= 4'd6;
    end

    always_comb begin
        state_d    = state_q;
        sync1_d    = btn;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        load_idx_d = load_idx_q;
        slot_d     = slot_q;
        f_d        = f_q;
        acc_d      = acc_q;
        dvd_d      = dvd_q;
        quo_d      = quo_q;
        result_d   = result_q;
        pt_d       = pt_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        p_neg_d    = p_neg_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_LOAD: begin
                if (press) begin
                    if (load_idx_q == 4'd0) ovf_d = 1'b0;
                    for (int i = 0; i < NS; i++)
                        if (load_idx_q == 4'(i)) slot_d[i] = sw_ext;
                    load_idx_d = load_idx_q + 4'd1;
                    if (load_idx_q == 4'(DEG + 2)) begin
                        state_d = S_EVAL;
                        cnt_d   = '0;
                        pt_d    = 2'd0;
                    end
                end
            end
            S_EVAL: begin
                if (cnt_q == '0) begin
                    acc_d = coef;
                end else begin
                    acc_d = hsum[RW-1:0];
                    if (step_ovf) ovf_d = 1'b1;
                end
                if (cnt_q == CNTW'(DEG)) begin
                    for (int i = 0; i < 3; i++)
                        if (pt_q == 2'(i)) f_d[i] = hsum[RW-1:0];
                    cnt_d = '0;
                    if (pt_q == 2'd2) state_d = S_SUM;
                    else              pt_d    = pt_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_SUM: begin
                if (sum_ovf) ovf_d = 1'b1;
                p_neg_d = pw[RW-1];
                dvd_d   = pw[RW-1] ? (RW'(0) - pw) : pw;
                rem_d   = 3'd0;
                quo_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                // RW shift/subtract steps, then one cycle to apply the sign
                if (cnt_q == CNTW'(RW)) begin
                    result_d = p_neg_q ? (RW'(0) - quo_q) : quo_q;
                    state_d  = S_DONE;
                end else begin
                    rem_d = q_bit ? 3'(rem_sh - 4'd6) : rem_sh[2:0];
                    dvd_d = {dvd_q[RW-2:0], 1'b0};
                    quo_d = {quo_q[RW-2:0], q_bit};
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_DONE: begin
                if (press) begin
                    ovf_d      = 1'b0;
                    slot_d[0]  = sw_ext;
                    load_idx_d = 4'd1;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            load_idx_q <= 4'd0;
            for (int i = 0; i < NS; i++) slot_q[i] <= '0;
            for (int i = 0; i < 3; i++)  f_q[i]    <= '0;
            acc_q      <= '0;
            dvd_q      <= '0;
            quo_q      <= '0;
            result_q   <= '0;
            pt_q       <= 2'd0;
            cnt_q      <= '0;
            rem_q      <= 3'd0;
            p_neg_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            load_idx_q <= load_idx_d;
            slot_q     <= slot_d;
            f_q        <= f_d;
            acc_q      <= acc_d;
            dvd_q      <= dvd_d;
            quo_q      <= quo_d;
            result_q   <= result_d;
            pt_q       <= pt_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            p_neg_q    <= p_neg_d;
            ovf_q      <= ovf_d;
        end
    end

    assign result   = result_q;
    assign busy     = (state_q == S_EVAL) || (state_q == S_SUM) || (state_q == S_DIV);
    assign done     = (state_q == S_DONE);
    assign ovf      = ovf_q;
    assign load_idx = load_idx_q;
endmodule

// File: tb/tb_simpson_poly_integrator.sv
// Directed bench for simpson_poly_integrator at default parameters (W=16, DEG=3, RW=32).
module tb_simpson_poly_integrator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [31:0] result;
    logic        busy, done, ovf;
    logic [3:0]  load_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    localparam int EXP_LAT = 3 * (3 + 1) + 32 + 2;

    simpson_poly_integrator dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
        .result(result), .busy(busy), .done(done), .ovf(ovf), .load_idx(load_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic press(input logic [15:0] v, input int hold);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Loads c3..c0 and a; optionally checks load_idx after every press.
    task automatic load5(input logic [15:0] c3, input logic [15:0] c2, input logic [15:0] c1,
                         input logic [15:0] c0, input logic [15:0] a, input int hold,
                         input bit chk_idx);
        logic [15:0] v [5];
        v[0] = c3; v[1] = c2; v[2] = c1; v[3] = c0; v[4] = a;
        for (int i = 0; i < 5; i++) begin
            press(v[i], hold);
            if (chk_idx) check($sformatf("load_idx_after_press%0d", i), load_idx, i + 1);
        end
    endtask

    // Presses b, then counts cycles from the capture until done (-1 on timeout).
    task automatic run_b(input logic [15:0] v, input bit busy_press, output int l);
        bit seen;
        seen = 1'b0;
        l    = -1;
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (load_idx == 4'd6) begin
                seen = 1'b1;
                break;
            end
        end
        btn = 1'b0;
        check("b_captured", seen, 1);
        check("busy_after_b", busy, 1);
        if (seen) begin
            for (int c = 1; c <= 200; c++) begin
                @(negedge clk);
                if (busy_press && c == 10) begin sw = 16'h0055; btn = 1'b1; end
                if (busy_press && c == 14) btn = 1'b0;
                if (busy_press && c == 20) check("busy_press_ignored_idx", load_idx, 6);
                if (done) begin
                    l = c;
                    break;
                end
            end
        end
        check("done_reached", (l > 0) ? 1 : 0, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_load_idx", load_idx, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // f = 4x^3+2x^2+x, a=1, b=6, long presses and a press while busy
        load5(16'd4, 16'd2, 16'd1, 16'd0, 16'd1, 20, 1'b1);
        run_b(16'd6, 1'b1, lat);
        check("t1_latency", lat, EXP_LAT);
        check("t1_result", $signed(result), 1220);
        check("t1_ovf", ovf, 0);
        check("t1_busy_low", busy, 0);
        check("t1_done_idx", load_idx, 6);
        $display("txn t1: a=1 b=6 result=%0d ovf=%0d latency=%0d", $signed(result), ovf, lat);

        // Same polynomial, a=0, b=2
        load5(16'd4, 16'd2, 16'd1, 16'd0, 16'd0, 1, 1'b0);
        run_b(16'd2, 1'b0, lat);
        check("t2_result", $signed(result), 23);
        $display("txn t2: a=0 b=2 result=%0d", $signed(result));

        // f = x^2, a=-4, b=0
        load5(16'd0, 16'd1, 16'd0, 16'd0, 16'hFFFC, 2, 1'b0);
        run_b(16'd0, 1'b0, lat);
        check("t3_result", $signed(result), 21);
        $display("txn t3: a=-4 b=0 result=%0d", $signed(result));

        // f = x^2, a=0, b=-4
        load5(16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 2, 1'b0);
        run_b(16'hFFFC, 1'b0, lat);
        check("t4_result", $signed(result), -21);
        check("t4_ovf", ovf, 0);
        $display("txn t4: a=0 b=-4 result=%0d", $signed(result));

        // Reset pulse during the divide, then a full reload
        load5(16'd4, 16'd2, 16'd1, 16'd0, 16'd1, 1, 1'b0);
        @(negedge clk);
        sw  = 16'd6;
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        repeat (22) @(negedge clk);
        check("t5_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_result", result, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_load_idx", load_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load5(16'd4, 16'd2, 16'd1, 16'd0, 16'd1, 1, 1'b0);
        run_b(16'd6, 1'b0, lat);
        check("t5_reload_result", $signed(result), 1220);
        check("t5_reload_latency", lat, EXP_LAT);
        $display("txn t5: reset during divide, reload result=%0d", $signed(result));

        // Overflow, then a press in DONE starts a new load
        load5(16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0, 1, 1'b0);
        run_b(16'h7FFF, 1'b0, lat);
        check("t6_ovf", ovf, 1);
        check("t6_done", done, 1);
        press(16'd3, 1);
        check("t6_ovf_cleared", ovf, 0);
        check("t6_done_cleared", done, 0);
        check("t6_load_idx", load_idx, 1);
        $display("txn t6: overflow case, after new press ovf=%0d done=%0d load_idx=%0d",
                 ovf, done, load_idx);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
